// File: rtl/lockin_demod.sv
// Multi-channel lock-in demodulator with a square-wave reference NCO.
// One channel per clock; each channel has first-order I/Q low-pass filter states.
module lockin_demod #(
  parameter int DW  = 16,
  parameter int AW  = 32,
  parameter int NCH = 2,
  parameter int PW  = 24
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PW-1:0]       freq_word,
  input  logic [3:0]          tc,
  input  logic [1:0]          gain,
  input  logic                in_valid,
  input  logic [NCH*DW-1:0]   in_data,
  input  logic                overrun_clr,
  output logic                ref_out,
  output logic                busy,
  output logic                out_valid,
  output logic [NCH*AW-1:0]   x_out,
  output logic [NCH*AW-1:0]   y_out,
  output logic                overrun
);

  localparam int SH = AW - DW - 2;
  localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic signed [AW+2:0] MAXV = {4'b0000, {(AW-1){1'b1}}};
  localparam logic signed [AW+2:0] MINV = {4'b1111, {(AW-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, PROC, DONE} state_t;

  state_t              state, state_nx;
  logic [PW-1:0]       phase, phase_l;
  logic [3:0]          tc_l;
  logic [1:0]          gain_l;
  logic [NCH*DW-1:0]   data_l;
  logic [CW-1:0]       ch;
  logic signed [AW-1:0] st_i [NCH];
  logic signed [AW-1:0] st_q [NCH];

  logic signed [DW-1:0] x_sel;
  logic signed [AW-1:0] si_sel, sq_sel, nx_i, nx_q;

  function automatic logic signed [DW-1:0] demod(input logic signed [DW-1:0] x,
                                                 input logic neg);
    if (!neg)
      return x;
    else if (x == {1'b1, {(DW-1){1'b0}}})
      return {1'b0, {(DW-1){1'b1}}};
    else
      return -x;
  endfunction

  function automatic logic signed [AW-1:0] extend(input logic signed [DW-1:0] m);
    logic signed [AW-1:0] e;
    e = AW'(m);
    return e <<< SH;
  endfunction

  // Difference carried in AW+1 bits so the target-minus-state step cannot wrap.
  function automatic logic signed [AW-1:0] filt(input logic signed [AW-1:0] st,
                                                input logic signed [AW-1:0] target,
                                                input logic [3:0] sh);
    logic signed [AW:0] d;
    d = (AW+1)'(target) - (AW+1)'(st);
    d = d >>> sh;
    return st + d[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] sat_out(input logic signed [AW-1:0] st,
                                            input logic [1:0] g);
    logic signed [AW+2:0] w;
    w = (AW+3)'(st) <<< g;
    if (w > MAXV)
      return MAXV[AW-1:0];
    else if (w < MINV)
      return MINV[AW-1:0];
    else
      return w[AW-1:0];
  endfunction

  assign ref_out = phase[PW-1];
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (in_valid) state_nx = PROC;
      PROC:    if (ch == CW'(NCH-1)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    x_sel  = '0;
    si_sel = '0;
    sq_sel = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (CW'(k) == ch) begin
        x_sel  = data_l[k*DW +: DW];
        si_sel = st_i[k];
        sq_sel = st_q[k];
      end
    end
    nx_i = filt(si_sel, extend(demod(x_sel, phase_l[PW-1])), tc_l);
    nx_q = filt(sq_sel, extend(demod(x_sel, ~(phase_l[PW-1] ^ phase_l[PW-2]))), tc_l);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase     <= '0;
      phase_l   <= '0;
      tc_l      <= '0;
      gain_l    <= '0;
      data_l    <= '0;
      ch        <= '0;
      out_valid <= 1'b0;
      x_out     <= '0;
      y_out     <= '0;
      overrun   <= 1'b0;
      for (int unsigned k = 0; k < NCH; k++) begin
        st_i[k] <= '0;
        st_q[k] <= '0;
      end
    end else begin
      phase     <= phase + freq_word;
      out_valid <= 1'b0;
      if (in_valid && busy)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          data_l  <= in_data;
          phase_l <= phase;
          tc_l    <= tc;
          gain_l  <= gain;
          ch      <= '0;
        end
        PROC: begin
          for (int unsigned k = 0; k < NCH; k++) begin
            if (CW'(k) == ch) begin
              st_i[k] <= nx_i;
              st_q[k] <= nx_q;
            end
          end
          ch <= ch + CW'(1);
        end
        DONE: begin
          for (int unsigned k = 0; k < NCH; k++) begin
            x_out[k*AW +: AW] <= sat_out(st_i[k], gain_l);
            y_out[k*AW +: AW] <= sat_out(st_q[k], gain_l);
          end
          out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lockin_demod.sv
// Bench for lockin_demod: vector table plus hand-written corner sequences,
// with expected results queued at stimulus time and checked on out_valid.
module tb_lockin_demod;

  localparam int DW = 16, AW = 32, NCH = 2, PW = 24;
  localparam int MINI = -2147483647 - 1;
  localparam int MAXI = 2147483647;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PW-1:0]     freq_word = '0;
  logic [3:0]        tc = '0;
  logic [1:0]        gain = '0;
  logic              in_valid = 1'b0;
  logic [NCH*DW-1:0] in_data = '0;
  logic              overrun_clr = 1'b0;
  logic              ref_out, busy, out_valid, overrun;
  logic [NCH*AW-1:0] x_out, y_out;

  lockin_demod #(.DW(DW), .AW(AW), .NCH(NCH), .PW(PW)) dut (
    .clk(clk), .rst(rst), .freq_word(freq_word), .tc(tc), .gain(gain),
    .in_valid(in_valid), .in_data(in_data), .overrun_clr(overrun_clr),
    .ref_out(ref_out), .busy(busy), .out_valid(out_valid),
    .x_out(x_out), .y_out(y_out), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x0, y0, x1, y1;
  } exp_t;

  typedef struct {
    logic       rst_first;
    logic [3:0] tc;
    logic [1:0] gain;
    int         d0, d1;
    int         x0, y0, x1, y1;
  } vec_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got out_valid=1 expected no output");
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("x0", $signed(x_out[0 +: AW]),  e.x0);
        chk("y0", $signed(y_out[0 +: AW]),  e.y0);
        chk("x1", $signed(x_out[AW +: AW]), e.x1);
        chk("y1", $signed(y_out[AW +: AW]), e.y1);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0;
    overrun_clr = 1'b0;
    freq_word = '0;
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) chk("wait_idle_timeout", 1, 0);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", q.size(), 0);
  endtask

  task automatic drive_set(input logic [3:0] t, input logic [1:0] g, input int a, input int b);
    tc = t;
    gain = g;
    in_data = {b[DW-1:0], a[DW-1:0]};
    in_valid = 1'b1;
  endtask

  task automatic apply_set(input logic [3:0] t, input logic [1:0] g, input int a, input int b,
                           input int ex0, input int ey0, input int ex1, input int ey1);
    exp_t e;
    wait_idle();
    e = '{ex0, ey0, ex1, ey1};
    q.push_back(e);
    drive_set(t, g, a, b);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    vecs[0] = '{1'b1, 4'd0, 2'd0, 1000, -1000, 16384000, -16384000, -16384000, 16384000};
    vecs[1] = '{1'b1, 4'd1, 2'd0, 1000, 0, 8192000, -8192000, 0, 0};
    vecs[2] = '{1'b0, 4'd1, 2'd0, 1000, 0, 12288000, -12288000, 0, 0};
    vecs[3] = '{1'b0, 4'd1, 2'd0, 1000, 0, 14336000, -14336000, 0, 0};
    vecs[4] = '{1'b1, 4'd0, 2'd3, 32767, -32768, MAXI, MINI, MINI, MAXI};
    vecs[5] = '{1'b0, 4'd0, 2'd1, 5, -7, 163840, -163840, -229376, 229376};
    vecs[6] = '{1'b1, 4'd2, 2'd0, 4000, 0, 16384000, -16384000, 0, 0};

    // Reset state while rst is held
    @(negedge clk);
    @(negedge clk);
    chk("rst_x0", $signed(x_out[0 +: AW]), 0);
    chk("rst_y1", $signed(y_out[AW +: AW]), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_ref_out", int'(ref_out), 0);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rst_first) do_reset();
      apply_set(vecs[i].tc, vecs[i].gain, vecs[i].d0, vecs[i].d1,
                vecs[i].x0, vecs[i].y0, vecs[i].x1, vecs[i].y1);
      wait_drain();
    end

    // Latency: accept at edge T, out_valid visible after edge T+3, idle again
    do_reset();
    q.push_back('{16384000, -16384000, -16384000, 16384000});
    drive_set(4'd0, 2'd0, 1000, -1000);
    @(negedge clk);
    in_valid = 1'b0;
    chk("lat_busy", int'(busy), 1);
    chk("lat_ov_t1", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_ov_t2", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_ov_t3", int'(out_valid), 0);
    @(negedge clk);
    chk("lat_ov_t4", int'(out_valid), 1);
    chk("lat_idle", int'(busy), 0);
    wait_drain();

    // Phase parked with MSB set: I sign negative, saturated negation of -32768
    do_reset();
    freq_word = 24'h800000;
    @(negedge clk);
    freq_word = '0;
    chk("ref_msb", int'(ref_out), 1);
    apply_set(4'd0, 2'd0, -32768, 0, 536854528, -536870912, 0, 0);
    wait_drain();

    // Overrun: drop while busy, with tc/gain changes that must not leak in
    do_reset();
    q.push_back('{1638400, -1638400, 3276800, -3276800});
    drive_set(4'd0, 2'd0, 100, 200);
    @(negedge clk);
    drive_set(4'd5, 2'd3, 9999, -9999);
    @(negedge clk);
    in_valid = 1'b0;
    wait_drain();
    chk("overrun_set", int'(overrun), 1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("overrun_clr", int'(overrun), 0);
    wait_idle();
    q.push_back('{1638400, -1638400, 3276800, -3276800});
    drive_set(4'd0, 2'd0, 100, 200);
    @(negedge clk);
    drive_set(4'd0, 2'd0, 7, 7);
    overrun_clr = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    overrun_clr = 1'b0;
    chk("overrun_clr_vs_drop", int'(overrun), 1);
    wait_drain();

    // Reset during PROC aborts the set
    do_reset();
    drive_set(4'd0, 2'd0, 100, 200);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_x0", $signed(x_out[0 +: AW]), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_no_valid", int'(out_valid), 0);
    apply_set(4'd0, 2'd0, -50, 25, -819200, 819200, 409600, -409600);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
